ms_alarm_scheduler: RTL and testbench

// - Shares one millisecond time base among CH requesters (note-off timers, tempo, debounce).
// - Each channel is armed with a delay in ms. Expirations are serialized onto a single

---
 rtl/ms_alarm_scheduler.sv | 166 ++++++++++++++++
 tb/tb_ms_alarm_scheduler.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_alarm_scheduler.sv
// Shared millisecond time base with CH one-shot alarms serialized onto a round-robin event port.
// Define ALARM_PERIODIC_EN to add the arm_periodic input and per-channel auto-reload.
//
// state     | meaning
// S_IDLE    | channel free, accepts an arm
// S_ARMED   | counting down rem on each ms tick
// S_PENDING | expired, waiting for grant and evt_ready

module ms_alarm_scheduler #(
    parameter int  CLK_DIV = 12500,
    parameter int  CH      = 4,
    parameter int  DW      = 16,
    localparam int CW      = $clog2(CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm_valid,
    input  logic [CW-1:0] arm_ch,
    input  logic [DW-1:0] arm_delay,
`ifdef ALARM_PERIODIC_EN
    input  logic          arm_periodic,
`endif
    output logic          arm_ready,
    input  logic          cancel,
    input  logic [CW-1:0] cancel_ch,
    output logic          evt_valid,
    output logic [CW-1:0] evt_ch,
    input  logic          evt_ready,
    output logic [DW-1:0] now_ms,
    output logic [CH-1:0] busy
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PTC = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_PENDING
    } ch_state_t;

    ch_state_t     st  [CH];
    logic [DW-1:0] rem [CH];
`ifdef ALARM_PERIODIC_EN
    logic [DW-1:0] reload   [CH];
    logic          periodic [CH];
`endif

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          tick;
    logic [CW-1:0] rr;
    logic [CW-1:0] evt_ch_inc;
    logic          hs;
    logic [CH-1:0] arm_hit;
    logic [CH-1:0] cancel_hit;
    logic [CH-1:0] hs_hit;
    logic [CH-1:0] cand;
    logic          grant_any;
    logic [CW-1:0] grant_ch;

    always_comb begin
        presc_nxt  = (presc == PTC) ? '0 : presc + PW'(1);
        hs         = evt_valid & evt_ready;
        evt_ch_inc = (evt_ch == CW'(CH - 1)) ? '0 : evt_ch + CW'(1);
        arm_ready  = 1'b0;
        busy       = '0;
        arm_hit    = '0;
        cancel_hit = '0;
        hs_hit     = '0;
        cand       = '0;
        for (int i = 0; i < CH; i++) begin
            busy[i]    = (st[i] != S_IDLE);
            arm_hit[i] = arm_valid && (arm_ch == CW'(i)) && (st[i] == S_IDLE);
            // the channel on the event port must complete its handshake
            cancel_hit[i] = cancel && (cancel_ch == CW'(i)) && (st[i] != S_IDLE)
                            && !(evt_valid && (evt_ch == CW'(i)));
            hs_hit[i]  = hs && (evt_ch == CW'(i));
            cand[i]    = (st[i] == S_PENDING) && !cancel_hit[i];
            if ((arm_ch == CW'(i)) && (st[i] == S_IDLE))
                arm_ready = 1'b1;
        end
    end

    always_comb begin
        logic [CW:0]   sum;
        logic [CW-1:0] idx;
        sum       = '0;
        idx       = '0;
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int k = 0; k < CH; k++) begin
            sum = {1'b0, rr} + (CW+1)'(k);
            if (sum >= (CW+1)'(CH))
                sum = sum - (CW+1)'(CH);
            idx = sum[CW-1:0];
            if (!grant_any && cand[idx]) begin
                grant_any = 1'b1;
                grant_ch  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            tick      <= 1'b0;
            now_ms    <= '0;
            rr        <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            for (int i = 0; i < CH; i++) begin
                st[i]  <= S_IDLE;
                rem[i] <= '0;
`ifdef ALARM_PERIODIC_EN
                reload[i]   <= '0;
                periodic[i] <= 1'b0;
`endif
            end
        end else begin
            presc <= presc_nxt;
            tick  <= (presc_nxt == PTC);
            if (tick)
                now_ms <= now_ms + DW'(1);

            for (int i = 0; i < CH; i++) begin
                if (arm_hit[i]) begin
                    // a tick coinciding with the arm is not counted
                    st[i]  <= (arm_delay == '0) ? S_PENDING : S_ARMED;
                    rem[i] <= arm_delay;
`ifdef ALARM_PERIODIC_EN
                    reload[i]   <= arm_delay;
                    periodic[i] <= arm_periodic;
`endif
                end else if (cancel_hit[i]) begin
                    st[i] <= S_IDLE;
                end else if (hs_hit[i]) begin
`ifdef ALARM_PERIODIC_EN
                    if (periodic[i]) begin
                        st[i]  <= (reload[i] == '0) ? S_PENDING : S_ARMED;
                        rem[i] <= reload[i];
                    end else begin
                        st[i] <= S_IDLE;
                    end
`else
                    st[i] <= S_IDLE;
`endif
                end else if ((st[i] == S_ARMED) && tick) begin
                    if (rem[i] == DW'(1))
                        st[i] <= S_PENDING;
                    else
                        rem[i] <= rem[i] - DW'(1);
                end
            end

            if (hs) begin
                evt_valid <= 1'b0;
                rr        <= evt_ch_inc;
            end else if (!evt_valid && grant_any) begin
                evt_valid <= 1'b1;
                evt_ch    <= grant_ch;
            end
        end
    end

endmodule

// File: tb/tb_ms_alarm_scheduler.sv
// Bench for ms_alarm_scheduler: scenario tasks plus randomized traffic against a due-time model.
// Covers the periodic feature when ALARM_PERIODIC_EN is defined.

module tb_ms_alarm_scheduler;

    localparam int D  = 4;
    localparam int CH = 4;
    localparam int DW = 6;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm_valid = 1'b0;
    logic [CW-1:0] arm_ch = '0;
    logic [DW-1:0] arm_delay = '0;
    logic          arm_ready;
    logic          cancel = 1'b0;
    logic [CW-1:0] cancel_ch = '0;
    logic          evt_valid;
    logic [CW-1:0] evt_ch;
    logic          evt_ready = 1'b0;
    logic [DW-1:0] now_ms;
    logic [CH-1:0] busy;
`ifdef ALARM_PERIODIC_EN
    logic          arm_periodic = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: an alarm is due on the clock edge where its d-th ms tick is consumed;
    // ticks are consumed on every edge number that is a multiple of D after reset.
    int cur;
    bit m_busy [CH];
    int m_due  [CH];
    bit m_per  [CH];
    int m_rel  [CH];
    bit m_evv;
    int m_evc;
    int m_rr;

    always #5 clk = ~clk;

    ms_alarm_scheduler #(.CLK_DIV(D), .CH(CH), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .arm_valid(arm_valid),
        .arm_ch(arm_ch),
        .arm_delay(arm_delay),
`ifdef ALARM_PERIODIC_EN
        .arm_periodic(arm_periodic),
`endif
        .arm_ready(arm_ready),
        .cancel(cancel),
        .cancel_ch(cancel_ch),
        .evt_valid(evt_valid),
        .evt_ch(evt_ch),
        .evt_ready(evt_ready),
        .now_ms(now_ms),
        .busy(busy)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int due_after(int edge_n, int d);
        return (edge_n / D + d) * D;
    endfunction

    function automatic bit m_pend(int i);
        return m_busy[i] && (m_due[i] <= cur);
    endfunction

    function automatic logic [CW+CH+DW:0] exp_vec();
        logic [CH-1:0] b;
        for (int i = 0; i < CH; i++) b[i] = m_busy[i];
        return {m_evv, CW'(m_evc), b, DW'((cur / D) % (1 << DW))};
    endfunction

    task automatic model_edge();
        int  n;
        int  sel;
        bit  hs;
        bit  arm_ok;
        bit  canc_ok;
        bit  per;
        n       = cur + 1;
        sel     = -1;
        per     = 1'b0;
`ifdef ALARM_PERIODIC_EN
        per     = arm_periodic;
`endif
        hs      = m_evv && evt_ready;
        arm_ok  = arm_valid && !m_busy[arm_ch];
        canc_ok = cancel && m_busy[cancel_ch] && !(m_evv && m_evc == int'(cancel_ch));
        if (!m_evv) begin
            for (int k = 0; k < CH; k++) begin
                int j;
                j = (m_rr + k) % CH;
                if (sel < 0 && m_pend(j) && !(canc_ok && int'(cancel_ch) == j)) sel = j;
            end
        end
        if (canc_ok) m_busy[cancel_ch] = 1'b0;
        if (hs) begin
            if (m_per[m_evc]) m_due[m_evc] = due_after(n, m_rel[m_evc]);
            else m_busy[m_evc] = 1'b0;
            m_evv = 1'b0;
            m_rr  = (m_evc + 1) % CH;
        end else if (!m_evv && sel >= 0) begin
            m_evv = 1'b1;
            m_evc = sel;
        end
        if (arm_ok) begin
            m_busy[arm_ch] = 1'b1;
            m_due[arm_ch]  = due_after(n, int'(arm_delay));
            m_per[arm_ch]  = per;
            m_rel[arm_ch]  = int'(arm_delay);
        end
        cur = n;
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        arm_valid = 1'b0;
        cancel    = 1'b0;
`ifdef ALARM_PERIODIC_EN
        arm_periodic = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        arm_valid = 1'b0;
        arm_ch    = '0;
        arm_delay = '0;
        cancel    = 1'b0;
        cancel_ch = '0;
        evt_ready = 1'b0;
`ifdef ALARM_PERIODIC_EN
        arm_periodic = 1'b0;
`endif
        repeat (2) @(negedge clk);
        cur = 0; m_evv = 0; m_evc = 0; m_rr = 0;
        for (int i = 0; i < CH; i++) begin
            m_busy[i] = 0; m_due[i] = 0; m_per[i] = 0; m_rel[i] = 0;
        end
        rst = 1'b0;
    endtask

    task automatic arm(int ch, int d);
        arm_valid = 1'b1;
        arm_ch    = CW'(ch);
        arm_delay = DW'(d);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({evt_valid, evt_ch, busy, now_ms} !== '0 || arm_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init got vec=%h ready=%b exp vec=0 ready=1",
                     {evt_valid, evt_ch, busy, now_ms}, arm_ready);
        end
        arm(1, 9);
        advance();
        repeat (9) advance();
        #1;
        checks++;
        if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_pre got %h exp %h", {evt_valid, evt_ch, busy, now_ms}, exp_vec());
        end
        arm_ch = 2'd1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (now_ms !== '0 || busy !== '0 || evt_valid !== 1'b0 || arm_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got now=%0d busy=%b ev=%b ready=%b exp 0 0 0 1",
                     now_ms, busy, evt_valid, arm_ready);
        end
    endtask

    task automatic test_single();
        int events;
        int ev_edge;
        events  = 0;
        ev_edge = -1;
        do_reset();
        evt_ready = 1'b1;
        arm(1, 3);
        #1;
        checks++;
        if (arm_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b exp 1", arm_ready);
        end
        advance();
        for (int c = 0; c < 40; c++) begin
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
                errors++;
                $display("FAIL single_vec edge %0d got %h exp %h", cur, {evt_valid, evt_ch, busy, now_ms}, exp_vec());
            end
            if (evt_valid && evt_ch == 2'd1) begin
                events++;
                if (ev_edge < 0) ev_edge = cur;
            end
            advance();
        end
        checks++;
        if (events !== 1 || ev_edge !== 13 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_event got count=%0d edge=%0d busy1=%b exp 1 13 0", events, ev_edge, busy[1]);
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int chs[3] = '{0, 2, 3};
        do_reset();
        foreach (chs[i]) begin
            arm(chs[i], 2);
            #1;
            checks++;
            if (arm_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready ch%0d got %b exp 1", chs[i], arm_ready);
            end
            advance();
        end
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_stall edge %0d got %h exp %h", cur, {evt_valid, evt_ch, busy, now_ms}, exp_vec());
            end
            advance();
        end
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
            errors++;
            $display("FAIL b2b_held got valid=%b ch=%0d exp 1 0", evt_valid, evt_ch);
        end
        evt_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_drain edge %0d got %h exp %h", cur, {evt_valid, evt_ch, busy, now_ms}, exp_vec());
            end
            if (evt_valid) q.push_back(int'(evt_ch));
            advance();
        end
        checks++;
        if (q.size() != 3 || q[0] != 0 || q[1] != 2 || q[2] != 3) begin
            errors++;
            $display("FAIL b2b_order got %p exp 0,2,3", q);
        end
    endtask

    task automatic test_cancel();
        int events;
        events = 0;
        do_reset();
        evt_ready = 1'b1;
        arm(2, 5);
        advance();
        repeat (8) advance();
        cancel    = 1'b1;
        cancel_ch = 2'd2;
        advance();
        #1;
        checks++;
        if (busy !== 4'b0000) begin
            errors++;
            $display("FAIL cancel_clear got busy=%b exp 0000", busy);
        end
        arm(2, 3);
        #1;
        checks++;
        if (arm_ready !== 1'b1) begin
            errors++;
            $display("FAIL cancel_rearm_ready got %b exp 1", arm_ready);
        end
        advance();
        #1;
        checks++;
        if (busy !== 4'b0100) begin
            errors++;
            $display("FAIL cancel_rearm got busy=%b exp 0100", busy);
        end
        cancel    = 1'b1;
        cancel_ch = 2'd2;
        advance();
        for (int c = 0; c < 40; c++) begin
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
                errors++;
                $display("FAIL cancel_vec edge %0d got %h exp %h", cur, {evt_valid, evt_ch, busy, now_ms}, exp_vec());
            end
            if (evt_valid) events++;
            advance();
        end
        checks++;
        if (events !== 0) begin
            errors++;
            $display("FAIL cancel_noevent got %0d events exp 0", events);
        end
    endtask

    task automatic test_zero_and_busy();
        do_reset();
        arm(3, 0);
        advance();
        #1;
        checks++;
        if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
            errors++;
            $display("FAIL zero_vec got %h exp %h", {evt_valid, evt_ch, busy, now_ms}, exp_vec());
        end
        advance();
        #1;
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin
            errors++;
            $display("FAIL zero_latency got valid=%b ch=%0d exp 1 3", evt_valid, evt_ch);
        end
        arm(3, 7);
        cancel    = 1'b1;
        cancel_ch = 2'd3;
        #1;
        checks++;
        if (arm_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got %b exp 0", arm_ready);
        end
        advance();
        #1;
        checks++;
        if (busy !== 4'b1000 || evt_valid !== 1'b1 || evt_ch !== 2'd3) begin
            errors++;
            $display("FAIL busy_hold got busy=%b valid=%b ch=%0d exp 1000 1 3", busy, evt_valid, evt_ch);
        end
        arm(1, 4);
        cancel    = 1'b1;
        cancel_ch = 2'd1;
        advance();
        #1;
        checks++;
        if (busy !== 4'b1010) begin
            errors++;
            $display("FAIL same_ch_arm_cancel got busy=%b exp 1010", busy);
        end
        arm(0, 4);
        cancel    = 1'b1;
        cancel_ch = 2'd1;
        advance();
        #1;
        checks++;
        if (busy !== 4'b1001) begin
            errors++;
            $display("FAIL diff_ch_arm_cancel got busy=%b exp 1001", busy);
        end
        evt_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
                errors++;
                $display("FAIL zero_drain edge %0d got %h exp %h", cur, {evt_valid, evt_ch, busy, now_ms}, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        int exp_now;
        int got_now;
        bit wrapped;
        logic [DW-1:0] prev;
        got_now = -1;
        wrapped = 1'b0;
        do_reset();
        evt_ready = 1'b1;
        repeat (238) advance();
        #1;
        checks++;
        if (now_ms !== DW'(59)) begin
            errors++;
            $display("FAIL wrap_preset got now=%0d exp 59", now_ms);
        end
        prev    = now_ms;
        exp_now = ((cur + 1) / D + 7) % (1 << DW);
        arm(0, 7);
        advance();
        for (int c = 0; c < 60; c++) begin
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_vec edge %0d got %h exp %h", cur, {evt_valid, evt_ch, busy, now_ms}, exp_vec());
            end
            if (now_ms < prev) wrapped = 1'b1;
            prev = now_ms;
            if (evt_valid && got_now < 0) got_now = int'(now_ms);
            advance();
        end
        checks++;
        if (!wrapped || got_now !== exp_now) begin
            errors++;
            $display("FAIL wrap_event got wrapped=%0d now=%0d exp 1 %0d", wrapped, got_now, exp_now);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            arm_valid = ($urandom % 3) == 0;
            arm_ch    = CW'($urandom_range(CH - 1, 0));
            arm_delay = DW'($urandom_range(5, 0));
            cancel    = ($urandom % 8) == 0;
            cancel_ch = CW'($urandom_range(CH - 1, 0));
            evt_ready = ($urandom % 4) != 0;
`ifdef ALARM_PERIODIC_EN
            arm_periodic = ($urandom % 4) == 0;
`endif
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec() || arm_ready !== !m_busy[arm_ch]) begin
                errors++;
                $display("FAIL random edge %0d got %h ready=%b exp %h ready=%b", cur,
                         {evt_valid, evt_ch, busy, now_ms}, arm_ready, exp_vec(), !m_busy[arm_ch]);
            end
            advance();
        end
    endtask

`ifdef ALARM_PERIODIC_EN
    task automatic test_periodic();
        int last;
        int gaps;
        int late;
        last = -1;
        gaps = 0;
        late = 0;
        do_reset();
        evt_ready    = 1'b1;
        arm(0, 2);
        arm_periodic = 1'b1;
        advance();
        for (int c = 0; c < 40; c++) begin
            #1;
            checks++;
            if ({evt_valid, evt_ch, busy, now_ms} !== exp_vec()) begin
                errors++;
                $display("FAIL periodic_vec edge %0d got %h exp %h", cur, {evt_valid, evt_ch, busy, now_ms}, exp_vec());
            end
            if (evt_valid) begin
                if (last >= 0) begin
                    gaps++;
                    checks++;
                    if (cur - last !== 8) begin
                        errors++;
                        $display("FAIL periodic_gap got %0d cycles exp 8", cur - last);
                    end
                end
                last = cur;
            end
            advance();
        end
        checks++;
        if (gaps < 3) begin
            errors++;
            $display("FAIL periodic_count got %0d gaps exp >=3", gaps);
        end
        while (m_evv) advance();
        cancel    = 1'b1;
        cancel_ch = 2'd0;
        advance();
        for (int c = 0; c < 30; c++) begin
            #1;
            if (evt_valid) late++;
            advance();
        end
        checks++;
        if (late !== 0 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL periodic_cancel got events=%0d busy=%b exp 0 0000", late, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_cancel();
        test_zero_and_busy();
        test_wrap();
`ifdef ALARM_PERIODIC_EN
        test_periodic();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
